// File: rtl/lane_unstripe_4to1.sv
// lane_unstripe_4to1
//   Receive-side lane un-striping for the 4-lane PHY datapath. One 4-lane word
//   (per-lane byte plus per-lane valid mask) is accepted per handshake. Its valid
//   lanes are then emitted in ascending lane order as a single byte stream with
//   valid/ready flow control. Lanes whose mask bit is clear are skipped without a
//   bubble cycle.
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          synchronous, active-low reset
//   in_valid       4-lane word offered
//   in_lane_valid  bit n = lane n carries a byte
//   in_data0..3    lane 0..3 bytes
//   in_ready       word accepted when in_valid && in_ready
//   out_data       current serialised byte (0 when nothing is pending)
//   out_valid      out_data valid
//   out_ready      downstream accepts; byte consumed on out_valid && out_ready
//   out_last       out_data is the last pending byte of the current word
//   err_empty      1-cycle pulse after a word with an all-zero lane mask was accepted
//   byte_count     total bytes forwarded since reset, wraps modulo 2^CNT_W
module lane_unstripe_4to1 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_lane_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              err_empty,
  output logic [CNT_W-1:0]  byte_count
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state, state_next;
  logic [3:0]        mask, mask_next;
  logic [DATA_W-1:0] hold      [4];
  logic [DATA_W-1:0] hold_next [4];
  logic [3:0]        lsb;
  logic              accept;
  logic              consume;

  // Output side and handshakes. SEND is held exactly while the pending mask is
  // non-zero, so the state doubles as the "any lane pending" flag.
  always_comb begin
    // Isolate the lowest pending lane: two's-complement trick.
    lsb       = mask & (~mask + 4'd1);
    out_valid = (state == SEND);
    // Exactly one bit set: clearing the lowest bit leaves nothing.
    out_last  = out_valid && ((mask & (mask - 4'd1)) == 4'd0);
    out_data  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lsb[i]) out_data = hold[i];
    end
    consume   = out_valid && out_ready;
    // A new word may load in the same cycle the final byte of the current one
    // leaves, which is what keeps full-mask words streaming at 1 byte/cycle.
    in_ready  = (state == IDLE) || (consume && out_last);
    accept    = in_valid && in_ready;
  end

  // Next-state: hold register, pending mask and FSM.
  always_comb begin
    mask_next  = mask;
    hold_next  = hold;
    state_next = state;

    if (accept) begin
      mask_next = in_lane_valid;
      hold_next = '{in_data0, in_data1, in_data2, in_data3};
    end else if (consume) begin
      mask_next = mask & ~lsb;
    end

    case (state)
      IDLE: if (accept && (in_lane_valid != 4'd0)) state_next = SEND;
      SEND: if (consume && out_last && !(accept && (in_lane_valid != 4'd0)))
              state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      mask       <= '0;
      hold       <= '{default: '0};
      byte_count <= '0;
      err_empty  <= 1'b0;
    end else begin
      state     <= state_next;
      mask      <= mask_next;
      hold      <= hold_next;
      if (consume) byte_count <= byte_count + 1'b1;
      err_empty <= accept && (in_lane_valid == 4'd0);
    end
  end

endmodule

// File: tb/tb_lane_unstripe_4to1.sv
// Testbench for lane_unstripe_4to1: directed scenarios plus a randomised
// back-pressure run, all checked against a byte scoreboard and a byte counter model.
module tb_lane_unstripe_4to1;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;   // small counter so wrap-around is reached quickly

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [3:0]    in_lane_valid;
  logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          err_empty;
  logic [CW-1:0] byte_count;

  always #5 clk = ~clk;

  lane_unstripe_4to1 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_lane_valid (in_lane_valid),
    .in_data0      (in_data0),
    .in_data1      (in_data1),
    .in_data2      (in_data2),
    .in_data3      (in_data3),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .err_empty     (err_empty),
    .byte_count    (byte_count)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sbq[$];
  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [CW-1:0] exp_count = '0;
  logic          err_pend  = 1'b0;
  bit            prev_cons = 1'b0;
  int unsigned   run_len   = 0;
  bit            mon_en    = 1'b0;
  bit            rand_mode = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Output monitor: pops the scoreboard on every handshake, tracks the byte
  // counter and the err_empty pulse, and measures back-to-back runs.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check_val("byte_count", byte_count, exp_count);
      check_val("err_empty", err_empty, err_pend);
      if (!reset) begin
        sbq.delete();
        exp_count = '0;
        err_pend  = 1'b0;
        prev_cons = 1'b0;
      end else begin
        if (sbq.size() == 0) check_val("idle_valid", out_valid, 0);
        if (out_valid && out_ready) begin
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val("out_data", out_data, e.data);
            check_val("out_last", out_last, e.last);
          end
          exp_count = exp_count + 1'b1;
          run_len   = prev_cons ? run_len + 1 : 1;
          prev_cons = 1'b1;
        end else begin
          prev_cons = 1'b0;
        end
        err_pend = in_valid && in_ready && (in_lane_valid == 4'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = 1'($urandom_range(0, 1));
  end

  // Offer one word (caller is just after a posedge); returns just after the
  // accepting edge. Expected bytes are queued when the handshake is seen.
  task automatic send_word(input logic [3:0] m, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    logic [DW-1:0] d[4];
    int unsigned   hi;
    bit            done;
    exp_t          e;
    d = '{d0, d1, d2, d3};
    in_valid = 1'b1;
    in_lane_valid = m;
    in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        hi = 0;
        for (int unsigned i = 0; i < 4; i++) if (m[i]) hi = i;
        for (int unsigned i = 0; i < 4; i++) begin
          if (m[i]) begin
            e.data = d[i];
            e.last = (i == hi);
            sbq.push_back(e);
          end
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_lane_valid = '0;
    check_val("accept_timeout", done, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sbq.size() != 0 || out_valid) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check_val("drain_timeout", (k < 200), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_lane_valid = '0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_byte_count", byte_count, 0);
    check_val("rst_err_empty", err_empty, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    mon_en = 1'b1;

    // 1: full word, first byte the cycle after acceptance
    send_word(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    check_val("t1_latency_valid", out_valid, 1);
    check_val("t1_latency_data", out_data, 8'h11);
    drain();
    check_val("t1_run_len", run_len, 4);
    check_val("t1_count", byte_count, 4);

    // 2: sparse mask, lanes skipped without bubbles
    send_word(4'b1010, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
    @(negedge clk);
    check_val("t2_first", out_data, 8'hBB);
    check_val("t2_first_last", out_last, 0);
    drain();
    check_val("t2_run_len", run_len, 2);

    // 3: back-pressure after the first byte
    send_word(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("t3_hold_data", out_data, 8'h22);
      check_val("t3_hold_valid", out_valid, 1);
      check_val("t3_hold_last", out_last, 0);
      check_val("t3_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // 4: two full words streamed back-to-back
    send_word(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04);
    send_word(4'b1111, 8'h05, 8'h06, 8'h07, 8'h08);
    drain();
    check_val("t4_run_len", run_len, 8);

    // 5: empty word
    send_word(4'b0000, 8'h99, 8'h98, 8'h97, 8'h96);
    @(negedge clk);
    check_val("t5_err_pulse", err_empty, 1);
    check_val("t5_out_valid", out_valid, 0);
    @(negedge clk);
    check_val("t5_err_clear", err_empty, 0);
    @(posedge clk); #1;

    // 6: reset in the middle of a word
    send_word(4'b1111, 8'h51, 8'h52, 8'h53, 8'h54);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("t6_out_valid", out_valid, 0);
    check_val("t6_byte_count", byte_count, 0);
    check_val("t6_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // 7: random words under random back-pressure
    rand_mode = 1'b1;
    for (int w = 0; w < 16; w++) begin
      send_word(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
